// File: rtl/comparador_serial_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : comparador_serial_ctrl_pkg
//  Description : Shared constants for the serial magnitude comparator:
//                controller state encodings, the default operand width and
//                a helper that sizes the bit-index register.
//  Revision    : 1.0 - initial release
// ============================================================================
package comparador_serial_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Controller states, 1-bit encoding.
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COMPARE = 1'b1;

    // Bits needed to address positions 0..w-1; never less than one bit.
    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/comparador_bit.sv
`default_nettype none
// ============================================================================
//  Module      : comparador_bit
//  Description : Combinational 1-bit magnitude comparator cell with a chain
//                enable. With en_in low all outputs are forced low.
//  Ports       : a, b    - bits under comparison
//                en_in   - chain enable (more significant bits are equal)
//                eq_out  - a == b, gated by en_in
//                gt      - a >  b, gated by en_in
//                lt      - a <  b, gated by en_in
//  Revision    : 1.0 - initial release
// ============================================================================
module comparador_bit (
    input  logic a,
    input  logic b,
    input  logic en_in,
    output logic eq_out,
    output logic gt,
    output logic lt
);

    assign eq_out = en_in & ~(a ^ b);
    assign gt     = en_in & a & ~b;
    assign lt     = en_in & ~a & b;

endmodule
`default_nettype wire

// File: rtl/comparador_serial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : comparador_serial_ctrl
//  Description : Sequential magnitude comparator for two WIDTH-bit unsigned
//                operands. One shared 1-bit cell is walked MSB-first, one bit
//                per clock, stopping at the first differing bit.
//  Ports       : clock  - rising-edge clock
//                reset  - synchronous, active-high reset
//                start  - comparison request, honoured only while idle
//                A, B   - operands, latched when start is accepted
//                busy   - comparison in progress
//                done   - one-cycle pulse, results updated this cycle
//                igual  - A == B (held)
//                maior  - A >  B (held)
//                menor  - A <  B (held)
//                ciclos - bit positions examined by the last comparison
//  Revision    : 1.0 - initial release
// ============================================================================
module comparador_serial_ctrl
    import comparador_serial_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             igual,
    output logic             maior,
    output logic             menor,
    output logic [CW-1:0]    ciclos
);

    localparam int IW = idx_width(WIDTH);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic [IW-1:0]    r_idx;
    logic [CW-1:0]    r_cnt;

    logic w_a_bit;
    logic w_b_bit;
    logic w_eq;
    logic w_gt;
    logic w_lt;

    assign w_a_bit = r_ra[r_idx];
    assign w_b_bit = r_rb[r_idx];

    // Enable tied high: reaching position idx implies every more
    // significant bit already compared equal.
    comparador_bit u_cell (
        .a      (w_a_bit),
        .b      (w_b_bit),
        .en_in  (1'b1),
        .eq_out (w_eq),
        .gt     (w_gt),
        .lt     (w_lt)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ra    <= '0;
            r_rb    <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            igual   <= 1'b0;
            maior   <= 1'b0;
            menor   <= 1'b0;
            ciclos  <= '0;
        end else begin
            // done is a single-cycle pulse unless a comparison finishes now.
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_ra    <= A;
                        r_rb    <= B;
                        r_idx   <= IW'(WIDTH - 1);
                        r_cnt   <= '0;
                        igual   <= 1'b0;
                        maior   <= 1'b0;
                        menor   <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (w_gt) begin
                        maior   <= 1'b1;
                        ciclos  <= r_cnt + CW'(1);
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_lt) begin
                        menor   <= 1'b1;
                        ciclos  <= r_cnt + CW'(1);
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_eq) begin
                        if (r_idx == '0) begin
                            igual   <= 1'b1;
                            ciclos  <= CW'(WIDTH);
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            // Guarded by idx > 0, so the index never wraps.
                            r_idx <= r_idx - IW'(1);
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/comparador_serial_ctrl.md
Name: comparador_serial_ctrl

Overview:
Sequential magnitude comparator controller for two WIDTH-bit unsigned operands. It shares a single 1-bit comparator cell across all bit positions. It latches the operands on a start pulse, walks the bits MSB-first with one bit per clock, and stops early at the first differing bit. It reports igual/maior/menor with a busy/done handshake, and serves as the area-reduced alternative to the fully parallel 4-bit comparator in wider datapaths.

Parameters:
WIDTH, 8, operand width in bits (>= 2)
CW, $clog2(WIDTH+1), width of the cycle-count output (derived; not overridden)

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  synchronous, active-high reset
start  input  1  request a comparison; sampled only when busy=0
A  input  WIDTH  operand A, latched on accepted start
B  input  WIDTH  operand B, latched on accepted start
busy  output  1  high while a comparison is in progress
done  output  1  one-cycle pulse: results valid and updated this cycle
igual  output  1  A == B (registered, held until next accepted start)
maior  output  1  A > B (registered, held)
menor  output  1  A < B (registered, held)
ciclos  output  CW  number of bit positions examined in the last comparison (1..WIDTH), held

Behaviour:
- One clock domain and one clock. Reset is synchronous and active-high. Ports are named clock and reset.
- Reset behaviour: the state goes to IDLE, and busy, done, igual, maior, menor and ciclos all clear to 0. Internal operand registers and the index clear to 0.
- Reset mid-comparison aborts the comparison immediately. No done pulse is produced and the results stay 0.
- States: IDLE and COMPARE (1-bit encoding).
- IDLE, with start=1 at an edge:
  - Latch A→ra and B→rb.
  - Set idx=WIDTH-1 and cnt=0.
  - Clear igual/maior/menor.
  - Go to COMPARE; busy=1 from the next cycle.
- IDLE, with start=0: hold all outputs.
- COMPARE, at each edge: the shared cell evaluates ra[idx] vs rb[idx] with the chain-enable input tied to 1 (all more significant bits are known equal).
  - ra[idx]=1, rb[idx]=0: maior←1, ciclos←cnt+1, done←1, go to IDLE.
  - ra[idx]=0, rb[idx]=1: menor←1, ciclos←cnt+1, done←1, go to IDLE.
  - Bits equal and idx=0: igual←1, ciclos←WIDTH, done←1, go to IDLE.
  - Bits equal and idx>0: idx←idx-1, cnt←cnt+1, stay in COMPARE.
- Latency: start accepted at edge t. For first differing bit position i (counted from the LSB), done is high during the cycle after edge t+(WIDTH-i). For equal operands, done is high after edge t+WIDTH.
- busy is low in the done cycle.
- Exactly one of igual/maior/menor is high after any completed comparison. All three are 0 only after reset or while busy.
- done is high for exactly one cycle per accepted start.
- start while busy=1 is ignored, with no queuing. Operand changes on A/B while busy have no effect.
- start high in the done cycle (state already IDLE) is accepted: a back-to-back comparison with no bubble.
- idx never wraps. Decrement occurs only when idx>0.
- Outputs are driven directly from registers, with no combinational path from inputs to outputs.

Decomposition:
- Shared package/include: state encodings (ST_IDLE, ST_COMPARE) and the default width constant.
- One natural sub-module: comparador_bit, a combinational 1-bit cell.
  - Inputs: a, b, en_in.
  - Outputs: eq_out=en_in&~(a^b), gt=en_in&a&~b, lt=en_in&~a&b.
- The controller instantiates exactly one comparador_bit, fed by ra[idx] and rb[idx].

Test Plan:
- Reset then idle: hold reset 2 cycles with start=0, release → busy=done=igual=maior=menor=0, ciclos=0.
- MSB decides: WIDTH=8, A=0x80, B=0x7F, start 1 cycle → done one cycle after first COMPARE edge, maior=1, igual=menor=0, ciclos=1.
- Full walk, equal operands: A=0x35, B=0x35 → busy for 8 cycles, then done; igual=1, ciclos=8.
- LSB decides: A=0x12, B=0x13 → menor=1, ciclos=8. Then, in the done cycle, start with A=0xF0, B=0x0F → accepted with no bubble, maior=1, ciclos=1.
- Start ignored while busy: A=0x01, B=0x01, then pulse start with A=0xFF, B=0x00 two cycles later → a single done pulse, igual=1, ciclos=8, and no second done.
- Reset mid-comparison: A=0x03, B=0x02, assert reset at the 3rd COMPARE cycle → next cycle busy=0, done never pulses, all results 0. A subsequent start compares correctly.
